sd_pixel_ram_writer: RTL
========================

# sd_pixel_ram_writer

Packs the byte stream from the SD-card reader into 16-bit RGB565 pixels and writes them, in raster order, into the frame buffer built on `generic_sync_ram` (16-bit data, 15-bit address). It sits directly upstream of the frame-buffer RAM and drives its `addr`/`din`/`we` port. One `start` pulse loads exactly one frame of `FRAME_PIXELS` pixels and ends with a `frame_done` pulse.

## Interface
- `ADDR_WIDTH`, 15: RAM address width. It must match the frame-buffer RAM.
- `FRAME_PIXELS`, 19200: pixels per frame (160x120). Legal range is 1 to 2^ADDR_WIDTH.
- Data width is fixed at 16 (two bytes per pixel). It is not a parameter.

Ports:
- `clk`  in  1: single clock. Every register updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle pulse that begins a frame. Honoured only in IDLE.
- `byte_in`  in  8: pixel byte from the SD reader.
- `byte_valid`  in  1: `byte_in` holds a valid byte.
- `byte_ready`  out  1: the block accepts a byte this cycle.
- `ram_addr`  out  ADDR_WIDTH: goes to RAM `addr`.
- `ram_din`  out  16: goes to RAM `din`.
- `ram_we`  out  1: goes to RAM `we`. Single-cycle pulse per pixel.
- `busy`  out  1: high while a frame load is in progress.
- `frame_done`  out  1: single-cycle pulse issued with the last pixel write.

## Operation
- States: IDLE, HI (waiting for the high byte), LO (waiting for the low byte).
- A byte transfer occurs on any cycle where `byte_valid && byte_ready`.
- `byte_ready` is 1 in HI and LO, 0 in IDLE. It is a registered output, derived from the state.
- `busy` is 1 in HI and LO, 0 in IDLE.
- IDLE:
  - `start`=1: pixel counter is cleared to 0; next state is HI.
  - Bytes offered in IDLE are not accepted.
- HI: a transfer latches `byte_in` into the hold register as pixel bits [15:8]; next state is LO. With no transfer, the block stays in HI.
- LO: a transfer produces, in the next cycle:
  - `ram_we`=1, `ram_din`={hold, `byte_in`}, `ram_addr`=pixel counter;
  - then the counter increments by 1.
  - If the counter equaled FRAME_PIXELS-1, the next state is IDLE and `frame_done`=1 in the same cycle as that final `ram_we`. Otherwise the next state is HI.
  - With no transfer, the block stays in LO.
- Byte order is big-endian: the first byte of a pair is the MSB. No colour conversion is applied.
- The counter is ADDR_WIDTH bits wide. It never wraps, because the frame terminates at FRAME_PIXELS-1.
- `start` while busy is ignored. The frame in progress continues unaffected.
- Between writes, `ram_addr` and `ram_din` hold their last values and `ram_we` is 0.
- Address order is raster: pixel k goes to address k.
- `rst` at any time:
  - all state clears and the block returns to IDLE;
  - a partial pixel in the hold register is discarded;
  - no write is issued in the reset cycle or the cycle after it.
  - RAM contents already written are left as they are.

## Timing
- Reset values: `byte_ready`=0, `busy`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `frame_done`=0, state=IDLE.
- `start` accepted at cycle T: `busy`=1 and `byte_ready`=1 from T+1.
- Low byte accepted at cycle N: the RAM write strobe appears at N+1. The data is in RAM after the edge ending N+1.
- Peak throughput is 1 byte per cycle, giving `ram_we` at most every 2nd cycle.
- The final low byte is accepted at N:
  - `ram_we`, `frame_done` and `busy`=0 all occur at N+1;
  - `byte_ready`=0 from N+1;
  - a new `start` is accepted from N+1.
- All outputs are registered. There is no combinational path from input to output.
- `byte_ready` does not depend on `byte_valid`.

## Test plan
- Reset values: assert `rst` for 2 cycles -> every output is 0, and `byte_ready` stays 0 while `byte_valid`=1 with no `start`.
- Continuous frame (FRAME_PIXELS=4): `start`, then bytes 12,34,56,78,9A,BC,DE,F0 (hex), one per cycle with `byte_valid` always high ->
  - writes at addr 0..3 of data 1234, 5678, 9ABC, DEF0 (hex);
  - `ram_we` on alternate cycles;
  - `frame_done` coincides with the addr-3 write;
  - `busy` falls in that same cycle.
- Gapped stream: random `byte_valid` gaps of 0-5 cycles between bytes -> identical RAM contents and addresses, and `frame_done` fires exactly once.
- `start` while busy: pulse `start` after pixel 1 -> ignored; the counter continues 2, 3 and the frame ends normally.
- Reset mid-pixel: `rst` after the high byte of pixel 2, then `start` and a full frame -> no stray write occurs, and writes restart at addr 0 with the correct pairing.
- Back-to-back frames: `start` in the same cycle as `frame_done` -> the second frame writes addr 0..3 again, with no lost or duplicated bytes.

Source files
------------

// File: rtl/sd_pixel_ram_writer_if.sv
// sd_pixel_ram_writer_if
// Groups the SD byte stream handshake and the frame-buffer RAM write port
// of sd_pixel_ram_writer.
//   start/byte_in/byte_valid        : producer -> writer
//   byte_ready/busy/frame_done      : writer status back to producer
//   ram_addr/ram_din/ram_we         : writer -> frame-buffer RAM
// The slave modport is the writer; the master modport is its environment.
interface sd_pixel_ram_writer_if #(
    parameter int unsigned ADDR_WIDTH = 15
);
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [15:0]           ram_din;
    logic                  ram_we;
    logic                  busy;
    logic                  frame_done;

    modport slave (
        input  start,
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output ram_addr,
        output ram_din,
        output ram_we,
        output busy,
        output frame_done
    );

    modport master (
        output start,
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  ram_addr,
        input  ram_din,
        input  ram_we,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/sd_pixel_ram_writer.sv
// sd_pixel_ram_writer
// Packs a big-endian byte stream into 16-bit RGB565 pixels and writes them in
// raster order (pixel k -> address k) into the frame-buffer RAM. One start
// pulse loads exactly FRAME_PIXELS pixels and ends with a frame_done pulse
// coincident with the final ram_we.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of sd_pixel_ram_writer_if (byte handshake, RAM port,
//          busy/frame_done status)
// All outputs are registered or decoded directly from the state register.
module sd_pixel_ram_writer #(
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned FRAME_PIXELS = 19200
) (
    input logic                 clk,
    input logic                 rst,
    sd_pixel_ram_writer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StHi, StLo} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastPix = ADDR_WIDTH'(FRAME_PIXELS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]            hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           din_q, din_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  active;
    logic                  xfer;

    // Ready/busy are decoded from the state register only, so they never
    // depend combinationally on byte_valid or start.
    assign active = (state_q != StIdle);
    assign xfer   = bus.byte_valid && active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cnt_d   = '0;
                    state_d = StHi;
                end
            end
            StHi: begin
                if (xfer) begin
                    hold_d  = bus.byte_in;
                    state_d = StLo;
                end
            end
            StLo: begin
                if (xfer) begin
                    we_d   = 1'b1;
                    din_d  = {hold_q, bus.byte_in};
                    addr_d = cnt_q;
                    // Post-increment may overflow on the final pixel when the
                    // frame fills the whole address space; start clears it.
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LastPix) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StHi;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    assign bus.byte_ready = active;
    assign bus.busy       = active;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_din    = din_q;
    assign bus.ram_we     = we_q;
    assign bus.frame_done = done_q;

endmodule
